// File: rtl/risc_pkg.sv
// risc_pkg: shared control-word layout and enums for the RISC-V-lite pipeline.
package risc_pkg;
    localparam int CW_RD = 6;
    localparam int CW_WR = 5;
    localparam int CW_SZ_HI = 4;
    localparam int CW_SZ_LO = 3;
    localparam int CW_UNS = 2;
    localparam int CW_WB_HI = 1;
    localparam int CW_WB_LO = 0;
    typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10} mem_size_t;
    typedef enum logic [1:0] {WB_NONE = 2'b00, WB_ALU = 2'b01, WB_MEM = 2'b10, WB_NPC4 = 2'b11} wb_sel_t;
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} mem_state_t;
endpackage

// File: rtl/load_store_align.sv
// load_store_align: byte-lane steering for stores and sign/zero extension for loads.
module load_store_align
    import risc_pkg::*;
(
    input  mem_size_t   size,
    input  logic        uns,
    input  logic [1:0]  addr,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = rdata[{addr, 3'b000} +: 8];
    assign h = addr[1] ? rdata[31:16] : rdata[15:0];
    assign be = size == SZ_B ? 4'b0001 << addr : size == SZ_H ? 4'b0011 << addr : 4'b1111;
    assign wdata = size == SZ_B ? {4{st_data[7:0]}} : size == SZ_H ? {2{st_data[15:0]}} : st_data;
    assign ld_data = size == SZ_B ? {{24{~uns & b[7]}}, b} :
                     size == SZ_H ? {{16{~uns & h[15]}}, h} : rdata;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: RISC-V-lite memory stage with req/gnt/rvalid data port and MEM/WB register.
// Define MEM_TIMEOUT_EN to add a watchdog that aborts stuck accesses through bus_err_o.
module mem_stage
    import risc_pkg::*;
#(
    parameter int N = 32,
    parameter int RD_W = 5,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_en,
    input  logic [6:0]      cwMEM,
    input  logic [N-1:0]    ALUres,
    input  logic [N-1:0]    Bout,
    input  logic [N-1:0]    NPC4_IN,
    input  logic [RD_W-1:0] Rdest_in,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [N-1:0]    dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [N-1:0]    dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [N-1:0]    dmem_rdata,
    output logic            stall_o,
    output logic            misalign_o,
    output logic            bus_err_o,
    output logic [N-1:0]    EXMEMfwd,
    output logic [N-1:0]    wb_data,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_we
);
    mem_state_t state, state_n;
    mem_size_t  size;
    wb_sel_t    wb_sel;
    logic       mem_rd, mem_wr, is_mem, misalign, access, req_phase, completing, timeout, bus_err;
    logic [N-1:0] ld_ext, ld_q, ld_val;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be positive");
    end

    assign mem_rd = cwMEM[CW_RD];
    assign mem_wr = cwMEM[CW_WR];
    assign size = mem_size_t'(cwMEM[CW_SZ_HI:CW_SZ_LO]);
    assign wb_sel = wb_sel_t'(cwMEM[CW_WB_HI:CW_WB_LO]);
    assign is_mem = mem_rd | mem_wr;
    assign misalign = is_mem & ((size == SZ_H & ALUres[0]) | (size == SZ_W & ALUres[1:0] != 2'b00));
    assign access = is_mem & ~misalign;
    assign req_phase = state == IDLE | state == REQ;
    // a load with both rd and wr set is treated as a load, so only pure stores finish on gnt
    assign completing = timeout | (req_phase & access & dmem_gnt & ~mem_rd) | (state == WAIT_R & dmem_rvalid);
    assign stall_o = access & state != DONE & ~completing;
    assign misalign_o = misalign;
    assign dmem_req = ~rst & access & req_phase & ~timeout;
    assign dmem_we = mem_wr & ~mem_rd;
    assign dmem_addr = {ALUres[N-1:2], 2'b00};
    assign EXMEMfwd = ALUres;
    assign ld_val = state == DONE ? ld_q : ld_ext;

    load_store_align u_align (
        .size    (size),
        .uns     (cwMEM[CW_UNS]),
        .addr    (ALUres[1:0]),
        .st_data (Bout),
        .rdata   (dmem_rdata),
        .be      (dmem_be),
        .wdata   (dmem_wdata),
        .ld_data (ld_ext)
    );

    always_comb begin
        state_n = state;
        if (completing)
            state_n = pipe_en ? IDLE : DONE;
        else if (req_phase & access)
            state_n = dmem_gnt ? WAIT_R : REQ;
        else if (state == DONE & pipe_en)
            state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ld_q <= '0;
        end else begin
            state <= state_n;
            ld_q <= state == WAIT_R & dmem_rvalid ? ld_ext : ld_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_data <= '0;
            wb_rd <= '0;
            wb_we <= 1'b0;
        end else if (pipe_en & ~stall_o) begin
            wb_data <= wb_sel == WB_MEM ? ld_val : wb_sel == WB_NPC4 ? NPC4_IN : ALUres;
            wb_rd <= Rdest_in;
            wb_we <= wb_sel != WB_NONE & ~misalign & ~bus_err & |Rdest_in;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1) > 8 ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    assign timeout = (state == REQ | state == WAIT_R) & cnt == CNT_W'(TIMEOUT_CYC);
    assign bus_err = timeout | err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            err_q <= 1'b0;
            bus_err_o <= 1'b0;
        end else begin
            cnt <= (state == REQ | state == WAIT_R) & ~completing ? cnt + 1'b1 : '0;
            err_q <= state_n == DONE & bus_err;
            bus_err_o <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
    assign bus_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;
    localparam int TO = 20;
    localparam logic [6:0] SW = 7'b0110000, SH = 7'b0101000, LB = 7'b1000010, LBU = 7'b1000110;
    localparam logic [6:0] LH = 7'b1001010, LHU = 7'b1001110, LW = 7'b1010010;
    localparam logic [6:0] ALU = 7'b0000001, LINK = 7'b0000011;

    logic clk = 1'b0, rst, pipe_en;
    logic [6:0] cwMEM;
    logic [31:0] ALUres, Bout, NPC4_IN, dmem_addr, dmem_wdata, dmem_rdata, EXMEMfwd, wb_data;
    logic [4:0] Rdest_in, wb_rd;
    logic dmem_req, dmem_we, dmem_gnt, dmem_rvalid, stall_o, misalign_o, bus_err_o, wb_we;
    logic [3:0] dmem_be;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    mem_stage #(.N(32), .RD_W(5), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .pipe_en(pipe_en), .cwMEM(cwMEM), .ALUres(ALUres), .Bout(Bout),
        .NPC4_IN(NPC4_IN), .Rdest_in(Rdest_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .stall_o(stall_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o), .EXMEMfwd(EXMEMfwd), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_we(wb_we)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        #1;
        tests++; if (wb_data !== 32'h0) begin fails++; $display("FAIL rst_wb_data: got %h expected 0", wb_data); end
        tests++; if (wb_rd !== 5'd0) begin fails++; $display("FAIL rst_wb_rd: got %0d expected 0", wb_rd); end
        tests++; if (wb_we !== 1'b0) begin fails++; $display("FAIL rst_wb_we: got %b expected 0", wb_we); end
        tests++; if (bus_err_o !== 1'b0) begin fails++; $display("FAIL rst_bus_err: got %b expected 0", bus_err_o); end
        tests++; if (dmem_req !== 1'b0 || stall_o !== 1'b0) begin fails++; $display("FAIL rst_req_stall: got %b%b expected 00", dmem_req, stall_o); end
        rst = 1'b0;
    endtask

    task automatic test_alu_wb();
        cwMEM = ALU; ALUres = 32'h55; Rdest_in = 5'd3;
        #1;
        tests++; if (EXMEMfwd !== 32'h55) begin fails++; $display("FAIL fwd: got %h expected 00000055", EXMEMfwd); end
        step();
        tests++; if (wb_data !== 32'h55 || wb_we !== 1'b1 || wb_rd !== 5'd3) begin fails++; $display("FAIL alu_wb: got %h/%b/%0d expected 00000055/1/3", wb_data, wb_we, wb_rd); end
        cwMEM = LINK; NPC4_IN = 32'h200; Rdest_in = 5'd4;
        step();
        tests++; if (wb_data !== 32'h200 || wb_we !== 1'b1) begin fails++; $display("FAIL link_wb: got %h/%b expected 00000200/1", wb_data, wb_we); end
        pipe_en = 1'b0; cwMEM = ALU; ALUres = 32'h77; Rdest_in = 5'd6;
        step();
        tests++; if (wb_data !== 32'h200 || wb_rd !== 5'd4) begin fails++; $display("FAIL hold_wb: got %h/%0d expected 00000200/4", wb_data, wb_rd); end
        pipe_en = 1'b1; Rdest_in = 5'd0;
        step();
        tests++; if (wb_data !== 32'h77 || wb_we !== 1'b0) begin fails++; $display("FAIL rd0_wb: got %h/%b expected 00000077/0", wb_data, wb_we); end
    endtask

    task automatic test_store_word();
        cwMEM = SW; ALUres = 32'h104; Bout = 32'hDEADBEEF; Rdest_in = 5'd9; dmem_gnt = 1'b1;
        #1;
        tests++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin fails++; $display("FAIL sw_req_we: got %b%b expected 11", dmem_req, dmem_we); end
        tests++; if (dmem_addr !== 32'h104 || dmem_be !== 4'b1111) begin fails++; $display("FAIL sw_addr_be: got %h/%b expected 00000104/1111", dmem_addr, dmem_be); end
        tests++; if (dmem_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_wdata: got %h expected deadbeef", dmem_wdata); end
        tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL sw_stall: got %b expected 0", stall_o); end
        step();
        dmem_gnt = 1'b0; cwMEM = 7'd0;
        tests++; if (wb_we !== 1'b0 || wb_rd !== 5'd9) begin fails++; $display("FAIL sw_wb: got %b/%0d expected 0/9", wb_we, wb_rd); end
    endtask

    task automatic test_load(input string nm, input logic [6:0] cw, input logic [31:0] addr, input logic [31:0] rd, input logic [31:0] exp);
        cwMEM = cw; ALUres = addr; Rdest_in = 5'd10; dmem_gnt = 1'b1; dmem_rdata = rd;
        #1;
        tests++; if (dmem_req !== 1'b1 || stall_o !== 1'b1 || dmem_addr !== {addr[31:2], 2'b00}) begin fails++; $display("FAIL %s_c0: got req %b stall %b addr %h expected 1 1 %h", nm, dmem_req, stall_o, dmem_addr, {addr[31:2], 2'b00}); end
        step();
        dmem_gnt = 1'b0;
        #1;
        tests++; if (dmem_req !== 1'b0 || stall_o !== 1'b1) begin fails++; $display("FAIL %s_c1: got req %b stall %b expected 0 1", nm, dmem_req, stall_o); end
        step();
        dmem_rvalid = 1'b1;
        #1;
        tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL %s_c2_stall: got %b expected 0", nm, stall_o); end
        step();
        dmem_rvalid = 1'b0; cwMEM = 7'd0;
        tests++; if (wb_data !== exp || wb_we !== 1'b1 || wb_rd !== 5'd10) begin fails++; $display("FAIL %s_wb: got %h/%b/%0d expected %h/1/10", nm, wb_data, wb_we, wb_rd, exp); end
    endtask

    task automatic test_misalign();
        cwMEM = LW; ALUres = 32'h101; Rdest_in = 5'd11; dmem_gnt = 1'b0;
        #1;
        tests++; if (misalign_o !== 1'b1 || dmem_req !== 1'b0 || stall_o !== 1'b0) begin fails++; $display("FAIL lw_misalign: got mis %b req %b stall %b expected 1 0 0", misalign_o, dmem_req, stall_o); end
        step();
        tests++; if (wb_we !== 1'b0 || wb_rd !== 5'd11) begin fails++; $display("FAIL misalign_wb: got %b/%0d expected 0/11", wb_we, wb_rd); end
        cwMEM = SH; ALUres = 32'h103;
        #1;
        tests++; if (misalign_o !== 1'b1 || dmem_req !== 1'b0) begin fails++; $display("FAIL sh_misalign: got %b/%b expected 1/0", misalign_o, dmem_req); end
        cwMEM = LH; ALUres = 32'h102;
        #1;
        tests++; if (misalign_o !== 1'b0 || dmem_req !== 1'b1) begin fails++; $display("FAIL lh_aligned: got %b/%b expected 0/1", misalign_o, dmem_req); end
        cwMEM = 7'd0;
        step();
    endtask

    task automatic test_store_half();
        cwMEM = SH; ALUres = 32'h102; Bout = 32'h1234ABCD; dmem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (dmem_req !== 1'b1 || stall_o !== 1'b1) begin fails++; $display("FAIL sh_wait%0d_req_stall: got %b%b expected 11", i, dmem_req, stall_o); end
            tests++; if (dmem_addr !== 32'h100 || dmem_be !== 4'b1100 || dmem_wdata !== 32'hABCDABCD) begin fails++; $display("FAIL sh_wait%0d_bus: got %h/%b/%h expected 00000100/1100/abcdabcd", i, dmem_addr, dmem_be, dmem_wdata); end
            step();
        end
        dmem_gnt = 1'b1;
        #1;
        tests++; if (dmem_req !== 1'b1 || stall_o !== 1'b0) begin fails++; $display("FAIL sh_gnt: got %b%b expected 10", dmem_req, stall_o); end
        step();
        dmem_gnt = 1'b0; cwMEM = 7'd0;
        #1;
        tests++; if (dmem_req !== 1'b0 || stall_o !== 1'b0) begin fails++; $display("FAIL sh_after: got %b%b expected 00", dmem_req, stall_o); end
    endtask

    task automatic test_done();
        cwMEM = ALU; ALUres = 32'h11; Rdest_in = 5'd7; pipe_en = 1'b1;
        step();
        cwMEM = LW; ALUres = 32'h108; dmem_rdata = 32'hCAFEF00D; dmem_gnt = 1'b1; pipe_en = 1'b0;
        step();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1;
        #1;
        tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL done_complete_stall: got %b expected 0", stall_o); end
        step();
        dmem_rvalid = 1'b0; dmem_rdata = 32'hBADBAD00;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++; if (stall_o !== 1'b0 || dmem_req !== 1'b0 || wb_data !== 32'h11) begin fails++; $display("FAIL done_hold%0d: got stall %b req %b wb %h expected 0 0 00000011", i, stall_o, dmem_req, wb_data); end
            step();
        end
        pipe_en = 1'b1;
        step();
        cwMEM = 7'd0;
        tests++; if (wb_data !== 32'hCAFEF00D || wb_we !== 1'b1 || wb_rd !== 5'd7) begin fails++; $display("FAIL done_wb: got %h/%b/%0d expected cafef00d/1/7", wb_data, wb_we, wb_rd); end
    endtask

    task automatic test_reset_mid();
        cwMEM = SW; ALUres = 32'h100; dmem_gnt = 1'b0; Rdest_in = 5'd12;
        step();
        rst = 1'b1;
        #1;
        tests++; if (dmem_req !== 1'b0) begin fails++; $display("FAIL rst_in_req: got %b expected 0", dmem_req); end
        step();
        rst = 1'b0; cwMEM = LW; dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0; rst = 1'b1;
        #1;
        tests++; if (dmem_req !== 1'b0) begin fails++; $display("FAIL rst_in_wait_req: got %b expected 0", dmem_req); end
        step();
        rst = 1'b0; cwMEM = 7'd0; ALUres = 32'h0; Rdest_in = 5'd0; dmem_rvalid = 1'b1; dmem_rdata = 32'h99;
        tests++; if (wb_data !== 32'h0 || wb_we !== 1'b0 || wb_rd !== 5'd0) begin fails++; $display("FAIL rst_mid_wb: got %h/%b/%0d expected 0/0/0", wb_data, wb_we, wb_rd); end
        #1;
        tests++; if (stall_o !== 1'b0 || dmem_req !== 1'b0) begin fails++; $display("FAIL rst_stray_rvalid: got %b%b expected 00", stall_o, dmem_req); end
        step();
        dmem_rvalid = 1'b0;
        tests++; if (wb_data !== 32'h0 || wb_we !== 1'b0) begin fails++; $display("FAIL rst_stray_wb: got %h/%b expected 0/0", wb_data, wb_we); end
        cwMEM = SW; ALUres = 32'h100; dmem_gnt = 1'b1;
        #1;
        tests++; if (dmem_req !== 1'b1 || stall_o !== 1'b0) begin fails++; $display("FAIL rst_idle_check: got %b%b expected 10", dmem_req, stall_o); end
        step();
        cwMEM = 7'd0; dmem_gnt = 1'b0;
    endtask

    task automatic test_timeout();
        int hits = 0;
        cwMEM = ALU; ALUres = 32'h5; Rdest_in = 5'd13;
        step();
        cwMEM = LW; ALUres = 32'h100; dmem_gnt = 1'b0;
        for (int i = 0; i < TO + 10; i++) begin
            step();
            if (bus_err_o === 1'b1) hits++;
        end
`ifdef MEM_TIMEOUT_EN
        tests++; if (hits != 1) begin fails++; $display("FAIL timeout_pulse: got %0d cycles expected 1", hits); end
        tests++; if (wb_we !== 1'b0) begin fails++; $display("FAIL timeout_wb_we: got %b expected 0", wb_we); end
`else
        tests++; if (hits != 0) begin fails++; $display("FAIL no_timeout_pulse: got %0d cycles expected 0", hits); end
        tests++; if (stall_o !== 1'b1 || wb_we !== 1'b1) begin fails++; $display("FAIL no_timeout_stall: got %b/%b expected 1/1", stall_o, wb_we); end
`endif
        cwMEM = 7'd0;
        step();
    endtask

    initial begin
        rst = 1'b1; pipe_en = 1'b1; cwMEM = 7'd0; ALUres = '0; Bout = '0; NPC4_IN = '0; Rdest_in = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        test_reset();
        test_alu_wb();
        test_store_word();
        test_load("lb", LB, 32'h103, 32'h80123456, 32'hFFFFFF80);
        test_load("lbu", LBU, 32'h103, 32'h80123456, 32'h00000080);
        test_load("lb_pos", LB, 32'h100, 32'h1234567F, 32'h0000007F);
        test_load("lh", LH, 32'h102, 32'h80011234, 32'hFFFF8001);
        test_load("lhu", LHU, 32'h100, 32'h0000F00D, 32'h0000F00D);
        test_load("lw", LW, 32'h104, 32'h89ABCDEF, 32'h89ABCDEF);
        test_misalign();
        test_store_half();
        test_done();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
